wb_uart_digit_ctrl: RTL and testbench

Parametrised Wishbone master that configures the `wbuart` core, polls its RX register, and stores received bytes in an N-digit display buffer. It optionally echoes each byte back through the TX register and multiplexes the buffer onto one-cold digit enables. It sits between `wbuart` and `hex7seg`, and supersedes the fixed 8-digit controller. It adds a configurable digit count, fill-wrap or scroll mode, a clear character, and an ack timeout.

---
 rtl/wb_uart_disp_pkg.sv | 29 ++
 rtl/wb_uart_digit_ctrl_scanner.sv | 50 +++++
 rtl/wb_uart_digit_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_wb_uart_digit_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_disp_pkg.sv
// Shared register map, RX status bit and controller state encoding for the
// Wishbone UART digit controller.
package wb_uart_disp_pkg;

  localparam logic [1:0] ADDR_SETUP = 2'd0;
  localparam logic [1:0] ADDR_RX    = 2'd2;
  localparam logic [1:0] ADDR_TX    = 2'd3;

  localparam int unsigned RX_EMPTY_BIT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETUP_WAIT,
    ST_RX_REQ,
    ST_RX_ACK,
    ST_TX_REQ,
    ST_TX_ACK,
    ST_GAP
  } ctrl_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/wb_uart_digit_ctrl_scanner.sv
// Time-multiplexes the digit buffer onto one-cold active-low enables; enable
// and segment byte are refreshed together once every SCAN_DIV cycles.
module digit_scanner
  import wb_uart_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 125_000
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_DIGITS-1:0][7:0] i_digits,
  output logic [NUM_DIGITS-1:0]      o_en,
  output logic [7:0]                 o_seg_data
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

  logic [SCAN_W-1:0]     r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_DIGITS-1:0] r_en;
  logic [7:0]            r_seg;

  logic                  w_tc;
  logic [NUM_DIGITS-1:0] w_onecold;

  assign w_tc      = (r_cnt == SCAN_W'(SCAN_DIV - 1));
  // Digit 0 is the leftmost, i.e. the most significant enable bit.
  assign w_onecold = ~(NUM_DIGITS'(1) << (IDX_W'(NUM_DIGITS - 1) - r_idx));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_en  <= '1;
      r_seg <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_en  <= w_onecold;
      r_seg <= i_digits[r_idx];
      r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + SCAN_W'(1);
    end
  end

  assign o_en       = r_en;
  assign o_seg_data = r_seg;

endmodule

// File: rtl/wb_uart_digit_ctrl.sv
// Wishbone master that configures wbuart, polls RX, stores bytes into an
// N-digit buffer (fill-wrap or scroll), optionally echoes to TX, and scans it out.
module wb_uart_digit_ctrl
  import wb_uart_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned BAUD_DIV    = 434,
  parameter int unsigned SETUP_WAIT  = 50_000_000,
  parameter int unsigned POLL_GAP    = 1500,
  parameter int unsigned SCAN_DIV    = 125_000,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter bit          SCROLL      = 1'b0,
  parameter bit          ECHO_EN     = 1'b1,
  parameter logic [7:0]  CLEAR_CHAR  = 8'h1B
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [1:0]            o_wb_addr,
  output logic [31:0]           o_wb_data,
  output logic [3:0]            o_wb_sel,
  input  logic                  i_wb_ack,
  input  logic [31:0]           i_wb_data,
  output logic [NUM_DIGITS-1:0] o_en,
  output logic [7:0]            o_seg_data,
  output logic                  o_rx_strobe,
  output logic                  o_timeout
);

  localparam int unsigned MAX_WAIT = max3(SETUP_WAIT, POLL_GAP, ACK_TIMEOUT);
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int unsigned PTR_W    = $clog2(NUM_DIGITS);

  ctrl_state_t                r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_cyc;
  logic                       r_stb;
  logic                       r_we;
  logic [1:0]                 r_addr;
  logic [31:0]                r_data;
  logic                       r_rx_strobe;
  logic                       r_timeout;
  logic [7:0]                 r_byte;
  logic [PTR_W-1:0]           r_ptr;
  logic [NUM_DIGITS-1:0][7:0] r_digits;

  logic       w_rx_empty;
  logic [7:0] w_rx_byte;
  logic       w_ack_expired;
  logic       w_unused_data;

  assign w_rx_empty    = i_wb_data[RX_EMPTY_BIT];
  assign w_rx_byte     = i_wb_data[7:0];
  assign w_ack_expired = (r_cnt == CNT_W'(ACK_TIMEOUT));
  assign w_unused_data = &{1'b0, i_wb_data[31:9]};

  // Wait counters restart at 1 on entry so the request cycle is the last idle cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_rx_strobe <= 1'b0;
      r_timeout   <= 1'b0;
      r_byte      <= '0;
      r_ptr       <= '0;
      r_digits    <= '0;
    end else begin
      r_rx_strobe <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_we    <= 1'b1;
          r_addr  <= ADDR_SETUP;
          r_data  <= 32'(BAUD_DIV);
          r_cnt   <= CNT_W'(1);
          r_state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (i_wb_ack) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_SETUP_WAIT;
          end else if (w_ack_expired) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_SETUP_WAIT: begin
          if (r_cnt >= CNT_W'(SETUP_WAIT - 1)) r_state <= ST_RX_REQ;
          else r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_RX_REQ: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= ADDR_RX;
          r_data  <= '0;
          r_cnt   <= CNT_W'(1);
          r_state <= ST_RX_ACK;
        end
        ST_RX_ACK: begin
          if (i_wb_ack) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_GAP;
            if (!w_rx_empty) begin
              if (w_rx_byte == CLEAR_CHAR) begin
                r_digits <= '0;
                r_ptr    <= '0;
              end else begin
                if (SCROLL) begin
                  r_digits <= {w_rx_byte, r_digits[NUM_DIGITS-1:1]};
                end else begin
                  r_digits[r_ptr] <= w_rx_byte;
                  r_ptr <= (r_ptr == PTR_W'(NUM_DIGITS - 1)) ? '0 : r_ptr + PTR_W'(1);
                end
                r_byte      <= w_rx_byte;
                r_rx_strobe <= 1'b1;
                if (ECHO_EN) r_state <= ST_TX_REQ;
              end
            end
          end else if (w_ack_expired) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_timeout <= 1'b1;
            r_cnt     <= CNT_W'(1);
            r_state   <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_TX_REQ: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_we    <= 1'b1;
          r_addr  <= ADDR_TX;
          r_data  <= {24'h0, r_byte};
          r_cnt   <= CNT_W'(1);
          r_state <= ST_TX_ACK;
        end
        ST_TX_ACK: begin
          if (i_wb_ack || w_ack_expired) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_timeout <= !i_wb_ack;
            r_cnt     <= CNT_W'(1);
            r_state   <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt >= CNT_W'(POLL_GAP - 1)) r_state <= ST_RX_REQ;
          else r_cnt <= r_cnt + CNT_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  digit_scanner #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV)
  ) u_scan (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_digits  (r_digits),
    .o_en      (o_en),
    .o_seg_data(o_seg_data)
  );

  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_stb;
  assign o_wb_we     = r_we;
  assign o_wb_addr   = r_addr;
  assign o_wb_data   = r_data;
  assign o_wb_sel    = 4'hF;
  assign o_rx_strobe = r_rx_strobe;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_wb_uart_digit_ctrl.sv
// Bench for wb_uart_digit_ctrl: one fill-mode/echo instance and one scroll-mode
// instance, each with a bench-side Wishbone slave and a write scoreboard.
module tb_wb_uart_digit_ctrl;

  localparam int unsigned ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0]       cyc, stb, we, ack, rxs, tmo;
  logic [1:0][1:0]  addr;
  logic [1:0][31:0] wdat, rdat;
  logic [1:0][3:0]  sel, en;
  logic [1:0][7:0]  seg;

  wb_uart_digit_ctrl #(
    .NUM_DIGITS(ND), .BAUD_DIV(434), .SETUP_WAIT(20), .POLL_GAP(8), .SCAN_DIV(4),
    .ACK_TIMEOUT(16), .SCROLL(1'b0), .ECHO_EN(1'b1), .CLEAR_CHAR(8'h1B)
  ) u_fill (
    .i_clk(clk), .i_reset(rst), .o_wb_cyc(cyc[0]), .o_wb_stb(stb[0]), .o_wb_we(we[0]),
    .o_wb_addr(addr[0]), .o_wb_data(wdat[0]), .o_wb_sel(sel[0]), .i_wb_ack(ack[0]),
    .i_wb_data(rdat[0]), .o_en(en[0]), .o_seg_data(seg[0]), .o_rx_strobe(rxs[0]),
    .o_timeout(tmo[0])
  );

  wb_uart_digit_ctrl #(
    .NUM_DIGITS(ND), .BAUD_DIV(434), .SETUP_WAIT(20), .POLL_GAP(8), .SCAN_DIV(4),
    .ACK_TIMEOUT(16), .SCROLL(1'b1), .ECHO_EN(1'b0), .CLEAR_CHAR(8'h1B)
  ) u_scroll (
    .i_clk(clk), .i_reset(rst), .o_wb_cyc(cyc[1]), .o_wb_stb(stb[1]), .o_wb_we(we[1]),
    .o_wb_addr(addr[1]), .o_wb_data(wdat[1]), .o_wb_sel(sel[1]), .i_wb_ack(ack[1]),
    .i_wb_data(rdat[1]), .o_en(en[1]), .o_seg_data(seg[1]), .o_rx_strobe(rxs[1]),
    .o_timeout(tmo[1])
  );

  int checks = 0;
  int errors = 0;

  int lat [2];
  bit noack_tx [2];
  int wcnt [2];
  int scnt [2];
  bit pstb [2];
  logic [7:0]  rxq0[$], rxq1[$];
  logic [33:0] expq0[$], expq1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] onecold(input int i);
    logic [3:0] v;
    v = 4'b0001 << (3 - i);
    return ~v;
  endfunction

  // Slave: ack after lat[d] cycles of stb, RX data from the byte queue (empty -> bit 8).
  initial begin
    ack = '0;
    rdat = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst || ack[d]) begin
          ack[d]  = 1'b0;
          wcnt[d] = 0;
        end else if (cyc[d] && stb[d]) begin
          wcnt[d]++;
          if (!(noack_tx[d] && we[d] && addr[d] == 2'd3) && wcnt[d] >= lat[d]) begin
            ack[d] = 1'b1;
            if (!we[d] && addr[d] == 2'd2) begin
              if (d == 0) rdat[d] = (rxq0.size() > 0) ? {24'h0, rxq0.pop_front()} : 32'h100;
              else        rdat[d] = (rxq1.size() > 0) ? {24'h0, rxq1.pop_front()} : 32'h100;
            end else begin
              rdat[d] = 32'h0;
            end
          end
        end else begin
          wcnt[d] = 0;
        end
      end
    end
  end

  // Monitor: every new bus request is checked; writes are popped from the scoreboard.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (cyc[d] && stb[d] && !pstb[d]) begin
          check($sformatf("dut%0d sel", d), 32'(sel[d]), 32'hF);
          if (we[d]) begin
            if ((d == 0 && expq0.size() == 0) || (d == 1 && expq1.size() == 0)) begin
              checks++;
              errors++;
              $display("FAIL dut%0d unexpected_write: got addr %0d data 0x%0h expected none",
                       d, addr[d], wdat[d]);
            end else begin
              e = (d == 0) ? expq0.pop_front() : expq1.pop_front();
              check($sformatf("dut%0d wr_addr", d), 32'(addr[d]), 32'(e[33:32]));
              check($sformatf("dut%0d wr_data", d), wdat[d], e[31:0]);
            end
          end else begin
            check($sformatf("dut%0d rd_addr", d), 32'(addr[d]), 32'd2);
          end
        end
        pstb[d] = cyc[d] && stb[d];
        if (rxs[d]) scnt[d]++;
      end
    end
  end

  task automatic wait_level(input int d, input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc[d] !== lvl && n < 200);
    if (cyc[d] !== lvl) begin
      checks++;
      errors++;
      $display("FAIL dut%0d wait_cyc: got no cyc=%0b within %0d cycles", d, lvl, n);
    end
  endtask

  // Waits for a fresh scan step of digit idx, then checks the displayed byte.
  task automatic check_digit(input int d, input int idx, input logic [7:0] exp);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (en[d] === onecold(idx) && n < 40);
    do begin @(negedge clk); n++; end while (en[d] !== onecold(idx) && n < 80);
    check($sformatf("dut%0d digit%0d", d, idx), {en[d], seg[d]}, {onecold(idx), exp});
  endtask

  task automatic drain0(input string name);
    int n;
    n = 0;
    while ((rxq0.size() > 0 || expq0.size() > 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(rxq0.size() + expq0.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] fill_bytes [5];
    fill_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    rst = 1'b1;
    lat[0] = 3; lat[1] = 1;
    noack_tx[0] = 1'b0; noack_tx[1] = 1'b0;
    scnt[0] = 0; scnt[1] = 0;
    pstb[0] = 1'b0; pstb[1] = 1'b0;
    rxq1.push_back(8'hA1);
    rxq1.push_back(8'hB2);
    repeat (3) @(negedge clk);

    check("reset bus", {28'h0, cyc[0], stb[0], we[0], 1'b0}, 32'h0);
    check("reset addr_data", {30'(wdat[0]), addr[0]}, 32'h0);
    check("reset sel", 32'(sel[0]), 32'hF);
    check("reset scan", {20'h0, en[0], seg[0]}, {20'h0, 4'hF, 8'h00});
    check("reset strobes", {30'h0, rxs[0], tmo[0]}, 32'h0);

    expq0.push_back({2'd0, 32'd434});
    expq1.push_back({2'd0, 32'd434});
    rst = 1'b0;

    wait_level(0, 1'b1, n);
    check("setup start", 32'(n), 32'd1);
    wait_level(0, 1'b0, n);
    check("setup cyc high", 32'(n), 32'd3);
    lat[0] = 1;
    wait_level(0, 1'b1, n);
    check("setup wait", 32'(n), 32'd20);
    wait_level(0, 1'b0, n);
    check("empty read high", 32'(n), 32'd1);
    wait_level(0, 1'b1, n);
    check("poll gap", 32'(n), 32'd8);
    check("empty no strobe", 32'(scnt[0]), 32'd0);

    foreach (fill_bytes[i]) begin
      rxq0.push_back(fill_bytes[i]);
      expq0.push_back({2'd3, 24'h0, fill_bytes[i]});
    end
    drain0("fill drain");
    check("fill strobes", 32'(scnt[0]), 32'd5);
    check_digit(0, 0, 8'h35);
    check_digit(0, 1, 8'h32);
    check_digit(0, 2, 8'h33);
    check_digit(0, 3, 8'h34);

    check_digit(1, 0, 8'h00);
    check_digit(1, 1, 8'h00);
    check_digit(1, 2, 8'hA1);
    check_digit(1, 3, 8'hB2);
    check("scroll strobes", 32'(scnt[1]), 32'd2);

    rxq0.push_back(8'h1B);
    drain0("clear drain");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) check_digit(0, i, 8'h00);
    check("clear no strobe", 32'(scnt[0]), 32'd5);
    rxq0.push_back(8'h41);
    expq0.push_back({2'd3, 32'h41});
    drain0("after clear drain");
    check_digit(0, 0, 8'h41);
    check_digit(0, 1, 8'h00);

    noack_tx[0] = 1'b1;
    rxq0.push_back(8'h55);
    expq0.push_back({2'd3, 32'h55});
    n = 0;
    do begin @(negedge clk); n++; end while (rxs[0] !== 1'b1 && n < 200);
    check("timeout strobe seen", 32'(rxs[0]), 32'd1);
    wait_level(0, 1'b1, n);
    check("tx start", {31'(n), we[0]}, {31'd1, 1'b1});
    n = 0;
    do begin @(negedge clk); n++; end while (tmo[0] !== 1'b1 && n < 40);
    check("timeout delay", 32'(n), 32'd16);
    check("timeout cyc drop", {30'h0, cyc[0], stb[0]}, 32'h0);
    @(negedge clk);
    check("timeout one pulse", 32'(tmo[0]), 32'd0);
    wait_level(0, 1'b1, n);
    check("resume gap", 32'(n + 1), 32'd8);
    noack_tx[0] = 1'b0;

    lat[0] = 5;
    rxq0.push_back(8'h77);
    n = 0;
    do begin @(negedge clk); n++; end while (!(cyc[0] === 1'b1 && we[0] === 1'b0) && n < 100);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset bus", {28'h0, cyc[0], stb[0], cyc[1], stb[1]}, 32'h0);
    check("midreset scan", {20'h0, en[0], seg[0]}, {20'h0, 4'hF, 8'h00});
    @(negedge clk);
    rxq0.delete();
    lat[0] = 1;
    expq0.push_back({2'd0, 32'd434});
    expq1.push_back({2'd0, 32'd434});
    rst = 1'b0;
    for (int i = 0; i < 4; i++) check_digit(0, i, 8'h00);
    check_digit(1, 3, 8'h00);
    check("midreset strobes", 32'(scnt[0]), 32'd7);
    repeat (40) @(negedge clk);
    check("scoreboard empty", 32'(expq0.size() + expq1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
